// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter that shares the four HEX displays between two 16-bit sources.
// Each accepted value is held for HOLD_CYCLES before the next write is accepted.
//
// state  | meaning
// S_IDLE | waiting for a write, readies follow the grant
// S_HOLD | value latched, hold timer counting down, no writes accepted
module hex_display_arbiter #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  input  logic        blank_lz,
  output logic [15:0] shown,
  output logic        owner,
  output logic        busy,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [15:0]      shown_nxt;
  logic             owner_nxt;
  logic             grant0, grant1;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      shown <= 16'h0000;
      owner <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shown <= shown_nxt;
      owner <= owner_nxt;
    end
  end

  // On a tie the requester that did not write the current value wins.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shown_nxt = shown;
    owner_nxt = owner;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      S_IDLE: begin
        grant0 = req0_valid & (~req1_valid | owner);
        grant1 = req1_valid & (~req0_valid | ~owner);
        if (grant0) begin
          shown_nxt = req0_data;
          owner_nxt = 1'b0;
          cnt_nxt   = CNT_LOAD;
          state_nxt = S_HOLD;
        end else if (grant1) begin
          shown_nxt = req1_data;
          owner_nxt = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
    endcase
  end

  assign req0_ready = grant0 & resetn;
  assign req1_ready = grant1 & resetn;
  assign busy       = (state == S_HOLD);

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // A digit blanks only when it and every more significant nibble are zero.
  logic blank1, blank2, blank3;
  assign blank3 = blank_lz & (shown[15:12] == 4'h0);
  assign blank2 = blank_lz & (shown[15:8]  == 8'h00);
  assign blank1 = blank_lz & (shown[15:4]  == 12'h000);

  assign HEX0 = seg7(shown[3:0]);
  assign HEX1 = blank1 ? 7'h7F : seg7(shown[7:4]);
  assign HEX2 = blank2 ? 7'h7F : seg7(shown[11:8]);
  assign HEX3 = blank3 ? 7'h7F : seg7(shown[15:12]);

endmodule

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Shares the board's four 7-segment displays (HEX3..HEX0) between two independent 16-bit value sources, e.g. the CPU debug port and the register viewer. The block arbitrates write requests round-robin and latches the winning value. It holds each accepted value on the displays for a guaranteed minimum time so it stays readable, then decodes the latched value into active-low segment patterns with optional leading-zero blanking. It sits between the datapath's debug taps and the board HEX pins.

## Interface
- HOLD_CYCLES, 50_000_000, minimum number of clock cycles an accepted value is held before another write is accepted; must be ≥ 1; counter width is clog2(HOLD_CYCLES) (minimum 1).
- clock  in  1  system clock; all state updates on rising edge.
- resetn  in  1  reset; synchronous and active-low.
- req0_valid  in  1  requester 0 has a value to display.
- req0_data  in  16  requester 0 value.
- req0_ready  out  1  requester 0 write accepted on this edge if req0_valid.
- req1_valid  in  1  requester 1 has a value to display.
- req1_data  in  16  requester 1 value.
- req1_ready  out  1  requester 1 write accepted on this edge if req1_valid.
- blank_lz  in  1  1 = blank leading zero digits.
- shown  out  16  currently latched value.
- owner  out  1  index of the requester that wrote `shown`.
- busy  out  1  1 while in HOLD (no writes accepted).
- HEX0..HEX3  out  7 each  active-low segments. Bit 0 = segment a … bit 6 = segment g. HEX0 is the least significant nibble.

## Operation
- States: IDLE, HOLD. busy = (state == HOLD).
- IDLE grant:
  - Only one valid → that requester is granted.
  - Both valid → the requester that is not `owner` is granted (round-robin).
  - reqN_ready = grant_N & (state == IDLE). It is combinational from the valids; a requester must never wait for ready before raising valid.
- Transfer on a rising edge with reqN_valid & reqN_ready:
  - shown <= reqN_data, owner <= N.
  - hold counter <= HOLD_CYCLES−1.
  - state <= HOLD.
- HOLD:
  - Both readies are 0.
  - The counter decrements each cycle.
  - On an edge with counter == 0, state <= IDLE.
- Valid may be held across HOLD. Valid may be dropped without a transfer; no state changes.
- Display:
  - HEXn = hex pattern of shown[4n+3:4n], decoded combinationally from the `shown` register. Patterns: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
  - Leading-zero blanking: HEXn (n = 1..3) = 7'h7F when blank_lz = 1 and nibbles n..3 of `shown` are all zero. HEX0 is never blanked.
  - blank_lz is not registered; it takes effect immediately.
- Reset (resetn low at an edge), from any state including mid-HOLD:
  - state = IDLE, counter = 0, shown = 16'h0000, owner = 1 (so req0 wins the first tie), busy = 0.
  - HEX0 = 7'h40. HEX1..3 = 7'h40, or 7'h7F if blank_lz.
  - Readies are 0 while resetn is low.

## Timing
- Accept latency: 0 cycles. Ready is asserted in the same cycle valid rises while IDLE. `shown`, `owner` and HEX outputs update on the accepting edge.
- HOLD lasts exactly HOLD_CYCLES cycles.
- Next acceptance is possible at the earliest HOLD_CYCLES+1 edges after the previous one.
- A waiting requester is granted on the first IDLE cycle. Under continuous contention the grants alternate 0,1,0,1…
- Exactly one transfer per accepting edge; both readies are never 1 together.
- resetn takes priority over any simultaneous handshake; no transfer occurs on a reset edge.

## Test plan
All scenarios run with HOLD_CYCLES = 4.
- Reset with blank_lz = 0 → shown = 0000, owner = 1, busy = 0, HEX3..0 = 40,40,40,40; both readies 0 while resetn low.
- req0_valid with data 1A2F for 1 cycle in IDLE:
  - → req0_ready = 1 that cycle; after the edge shown = 1A2F, owner = 0, busy = 1.
  - HEX3..0 = 79,08,24,0E.
  - busy falls after 4 cycles.
- Both valid from the first post-reset cycle, req0 = 1111, req1 = 2222:
  - → req0 accepted at edge t; req1_ready stays 0 through HOLD.
  - req1 accepted at edge t+5; owner = 1.
- Both held valid continuously → accepts at t, t+5, t+10, t+15 with owners 0,1,0,1.
- blank_lz = 1:
  - shown = 0040 → HEX3..0 = 7F,7F,19,40.
  - shown = 0000 → 7F,7F,7F,40.
  - shown = 8000 → 00,40,40,40.
  - Toggling blank_lz changes the HEX outputs in the same cycle.
- resetn low for 1 edge during HOLD, 2 cycles after accepting ABCD → shown = 0000, busy = 0; a pending req1 is accepted on the next edge.
